// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch/decode sequencer in front of the execution unit. Reads opcode and
//   optional operand bytes from an 8-bit program memory, presents each valid
//   instruction for exactly one clock, stretches sleep instructions and stops
//   for good on 0xFF.
//
// Ports
//   clk      in   system clock, everything on posedge
//   reset    in   synchronous active-high reset
//   run      in   1 = fetch and issue, 0 = stop at the next instruction boundary
//   pm_addr  out  program memory address (holds when pm_rd = 0)
//   pm_rd    out  program memory read strobe, data returns one cycle later
//   pm_data  in   program memory read data
//   stall    in   execution unit busy, blocks issue while 1
//   code     out  opcode, 0x00 outside the issue cycle
//   in_data  out  operand, 0x00 for one-byte opcodes and outside issue
//   rd       out  1 in the issue cycle of load_rom (0x01)
//   wr       out  1 in the issue cycle of out_rom (0x03)
//   issue    out  1 in the cycle code/in_data/rd/wr are valid
//   halted   out  1 while halted
//   bad_op   out  sticky undefined-opcode flag, cleared only by reset
//
// States
//   state        | meaning
//   S_IDLE       | waiting for run
//   S_FETCH_OP   | pm_rd high for the opcode byte at pc
//   S_DECODE     | opcode on pm_data, classify it, pc += 1
//   S_FETCH_ARG  | pm_rd high for the operand byte at pc
//   S_LATCH_ARG  | operand on pm_data, pc += 1
//   S_ISSUE      | instruction presented (issue=1) unless stalled
//   S_SLEEP      | post-sleep wait
//   S_HALT       | terminal, left only through reset
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          SLEEP_CYCLES = 10000,
  parameter logic [7:0]  PC_START     = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [7:0] pm_addr,
  output logic       pm_rd,
  input  logic [7:0] pm_data,
  input  logic       stall,
  output logic [7:0] code,
  output logic [7:0] in_data,
  output logic       rd,
  output logic       wr,
  output logic       issue,
  output logic       halted,
  output logic       bad_op
);

  // The sleep wait is measured from the sleep issue cycle: the next opcode
  // fetch lands exactly SLEEP_CYCLES cycles after it. The issue cycle itself
  // is the first of those, so the SLEEP state lasts SLEEP_CYCLES-1 cycles and
  // is skipped entirely when SLEEP_CYCLES is 1.
  localparam int              CNT_W      = (SLEEP_CYCLES > 2) ? $clog2(SLEEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SLEEP_LOAD = (SLEEP_CYCLES > 1) ? CNT_W'(SLEEP_CYCLES - 2) : '0;
  localparam bit              SLEEP_SKIP = (SLEEP_CYCLES <= 1);

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_LOAD_ROM = 8'h01;
  localparam logic [7:0] OP_LOAD_NUM = 8'h02;
  localparam logic [7:0] OP_OUT_ROM  = 8'h03;
  localparam logic [7:0] OP_CLR      = 8'h04;
  localparam logic [7:0] OP_INC      = 8'h05;
  localparam logic [7:0] OP_SLEEP    = 8'h0A;
  localparam logic [7:0] OP_DEC      = 8'h0C;
  localparam logic [7:0] OP_OUT      = 8'h0D;
  localparam logic [7:0] OP_HALT     = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_DECODE,
    S_FETCH_ARG,
    S_LATCH_ARG,
    S_ISSUE,
    S_SLEEP,
    S_HALT
  } state_t;

  state_t           state, state_n;
  logic [7:0]       pc, pc_n;
  logic [7:0]       op_q, op_n;
  logic [7:0]       arg_q, arg_n;
  logic [CNT_W-1:0] sleep_cnt, sleep_cnt_n;

  logic [7:0]       pm_addr_n;
  logic             pm_rd_n;
  logic [7:0]       code_n;
  logic [7:0]       in_data_n;
  logic             rd_n;
  logic             wr_n;
  logic             issue_n;
  logic             halted_n;
  logic             bad_op_n;

  function automatic logic is_two_byte(input logic [7:0] o);
    return (o == OP_LOAD_ROM) || (o == OP_LOAD_NUM) || (o == OP_OUT_ROM);
  endfunction

  function automatic logic is_one_byte(input logic [7:0] o);
    return (o == OP_CLR) || (o == OP_INC) || (o == OP_SLEEP) ||
           (o == OP_DEC) || (o == OP_OUT);
  endfunction

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    op_n        = op_q;
    arg_n       = arg_q;
    sleep_cnt_n = sleep_cnt;
    bad_op_n    = bad_op;
    pm_addr_n   = pm_addr;

    case (state)
      S_IDLE: begin
        if (run) state_n = S_FETCH_OP;
      end

      S_FETCH_OP: begin
        state_n = S_DECODE;
      end

      S_DECODE: begin
        op_n  = pm_data;
        arg_n = 8'h00;
        pc_n  = pc + 8'd1;
        if (is_two_byte(pm_data)) begin
          state_n = S_FETCH_ARG;
        end else if (pm_data == OP_HALT) begin
          state_n = S_HALT;
        end else if (is_one_byte(pm_data)) begin
          state_n = S_ISSUE;
        end else begin
          // undefined opcode: flag it, skip it, keep going
          bad_op_n = 1'b1;
          state_n  = run ? S_FETCH_OP : S_IDLE;
        end
      end

      S_FETCH_ARG: begin
        state_n = S_LATCH_ARG;
      end

      S_LATCH_ARG: begin
        arg_n   = pm_data;
        pc_n    = pc + 8'd1;
        state_n = S_ISSUE;
      end

      S_ISSUE: begin
        // issue is the registered "presented this cycle" flag; until it has
        // been high once the instruction is still waiting on stall
        if (issue) begin
          if (op_q == OP_SLEEP && !SLEEP_SKIP) begin
            state_n     = S_SLEEP;
            sleep_cnt_n = SLEEP_LOAD;
          end else begin
            state_n = run ? S_FETCH_OP : S_IDLE;
          end
        end
      end

      S_SLEEP: begin
        if (sleep_cnt == '0) begin
          state_n = run ? S_FETCH_OP : S_IDLE;
        end else begin
          sleep_cnt_n = sleep_cnt - CNT_W'(1);
        end
      end

      S_HALT: begin
        state_n = S_HALT;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // All outputs are registered, so they are derived from the next state.
    pm_rd_n = (state_n == S_FETCH_OP) || (state_n == S_FETCH_ARG);
    if (pm_rd_n) pm_addr_n = pc_n;

    // stall sampled on the edge into (or while holding) ISSUE decides
    // whether the following cycle carries the instruction
    issue_n   = (state_n == S_ISSUE) && !stall;
    code_n    = issue_n ? op_n : OP_NOP;
    in_data_n = issue_n ? arg_n : 8'h00;
    rd_n      = issue_n && (op_n == OP_LOAD_ROM);
    wr_n      = issue_n && (op_n == OP_OUT_ROM);
    halted_n  = (state_n == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= PC_START;
      op_q      <= 8'h00;
      arg_q     <= 8'h00;
      sleep_cnt <= '0;
      pm_addr   <= PC_START;
      pm_rd     <= 1'b0;
      code      <= 8'h00;
      in_data   <= 8'h00;
      rd        <= 1'b0;
      wr        <= 1'b0;
      issue     <= 1'b0;
      halted    <= 1'b0;
      bad_op    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      op_q      <= op_n;
      arg_q     <= arg_n;
      sleep_cnt <= sleep_cnt_n;
      pm_addr   <= pm_addr_n;
      pm_rd     <= pm_rd_n;
      code      <= code_n;
      in_data   <= in_data_n;
      rd        <= rd_n;
      wr        <= wr_n;
      issue     <= issue_n;
      halted    <= halted_n;
      bad_op    <= bad_op_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] pm_addr;
  logic       pm_rd;
  logic [7:0] pm_data;
  logic       stall;
  logic [7:0] code;
  logic [7:0] in_data;
  logic       rd;
  logic       wr;
  logic       issue;
  logic       halted;
  logic       bad_op;

  logic [7:0] mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  instr_fetch #(
    .SLEEP_CYCLES (4),
    .PC_START     (8'h00)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .pm_addr (pm_addr),
    .pm_rd   (pm_rd),
    .pm_data (pm_data),
    .stall   (stall),
    .code    (code),
    .in_data (in_data),
    .rd      (rd),
    .wr      (wr),
    .issue   (issue),
    .halted  (halted),
    .bad_op  (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous program memory: one-cycle read latency
  always @(posedge clk) begin
    if (pm_rd) pm_data <= mem[pm_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] val);
    for (int i = 0; i < 256; i++) mem[i] = val;
  endtask

  // leaves reset asserted on a negedge; caller releases it
  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    stall = 1'b0;
    step();
    step();
  endtask

  task automatic release_run();
    reset = 1'b0;
    run   = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    run     = 1'b0;
    stall   = 1'b0;
    pm_data = 8'h00;
    fill(8'h00);

    // ---- 1: load_num then out, reset state --------------------------------
    fill(8'h04);
    mem[0] = 8'h02; mem[1] = 8'h5A; mem[2] = 8'h0D;
    do_reset();
    chk("rst_code",    code,    8'h00);
    chk("rst_issue",   issue,   8'h00);
    chk("rst_pm_rd",   pm_rd,   8'h00);
    chk("rst_pm_addr", pm_addr, 8'h00);
    chk("rst_halted",  halted,  8'h00);
    chk("rst_bad_op",  bad_op,  8'h00);
    release_run();
    for (int c = 0; c < 9; c++) begin
      step();
      chk($sformatf("t1_issue_c%0d", c), issue, (c == 4 || c == 7) ? 8'h01 : 8'h00);
      chk($sformatf("t1_pm_rd_c%0d", c), pm_rd,
          (c == 0 || c == 2 || c == 5 || c == 8) ? 8'h01 : 8'h00);
      if (c == 4) begin
        chk("t1_code_ldnum",  code,    8'h02);
        chk("t1_in_ldnum",    in_data, 8'h5A);
      end
      if (c == 7) begin
        chk("t1_code_out",    code,    8'h0D);
        chk("t1_in_out",      in_data, 8'h00);
      end
      if (c == 8) chk("t1_pc3", pm_addr, 8'h03);
    end
    // reset in the middle of an instruction: nothing issued
    reset = 1'b1;
    step();
    chk("t1_midrst_issue", issue, 8'h00);
    chk("t1_midrst_pm_rd", pm_rd, 8'h00);
    chk("t1_midrst_addr",  pm_addr, 8'h00);

    // ---- 2: load_rom / out_rom, run dropped mid-instruction ---------------
    fill(8'h04);
    mem[0] = 8'h01; mem[1] = 8'h10; mem[2] = 8'h03; mem[3] = 8'h20;
    do_reset();
    release_run();
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("t2_rd_c%0d", c), rd, (c == 4) ? 8'h01 : 8'h00);
      chk($sformatf("t2_wr_c%0d", c), wr, (c == 9) ? 8'h01 : 8'h00);
      if (c == 4) begin
        chk("t2_code_ldrom", code,    8'h01);
        chk("t2_in_ldrom",   in_data, 8'h10);
      end
      if (c == 7) chk("t2_argaddr", pm_addr, 8'h03);
      if (c == 9) begin
        chk("t2_code_outrom", code,    8'h03);
        chk("t2_in_outrom",   in_data, 8'h20);
      end
      if (c >= 10) chk($sformatf("t2_stop_c%0d", c), pm_rd, 8'h00);
      if (c == 6) run = 1'b0;
    end

    // ---- 3: stall over the issue of inc ----------------------------------
    fill(8'h04);
    mem[0] = 8'h05;
    do_reset();
    release_run();
    step();
    stall = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t3_stall_issue_%0d", k), issue, 8'h00);
      chk($sformatf("t3_stall_code_%0d", k),  code,  8'h00);
    end
    stall = 1'b0;
    step();
    chk("t3_issue",    issue, 8'h01);
    chk("t3_code",     code,  8'h05);
    step();
    chk("t3_single",   issue, 8'h00);
    chk("t3_refetch",  pm_rd, 8'h01);
    chk("t3_nextaddr", pm_addr, 8'h01);

    // ---- 4: sleep stretch (SLEEP_CYCLES = 4) ------------------------------
    fill(8'h04);
    mem[0] = 8'h0A; mem[1] = 8'h04;
    do_reset();
    release_run();
    for (int c = 0; c < 9; c++) begin
      step();
      chk($sformatf("t4_pm_rd_c%0d", c), pm_rd, (c == 0 || c == 6) ? 8'h01 : 8'h00);
      if (c == 2) chk("t4_code_sleep", code, 8'h0A);
      if (c == 6) chk("t4_addr",       pm_addr, 8'h01);
      if (c == 8) chk("t4_code_clr",   code, 8'h04);
    end

    // ---- 5: operand fetched across the pc wrap ----------------------------
    fill(8'h04);
    mem[8'h00] = 8'h33;
    mem[8'hFF] = 8'h02;
    do_reset();
    release_run();
    begin
      int n;
      n = 0;
      step();
      while (!(issue === 1'b1 && code === 8'h02) && n < 1200) begin
        step();
        n++;
      end
      chk("t5_reached", (n < 1200) ? 8'h01 : 8'h00, 8'h01);
    end
    chk("t5_operand", in_data, 8'h33);
    step();
    chk("t5_pm_rd",   pm_rd,   8'h01);
    chk("t5_pc",      pm_addr, 8'h01);

    // ---- 6: undefined opcode, halt, reset recovery ------------------------
    fill(8'h04);
    mem[0] = 8'h07; mem[1] = 8'hFF;
    do_reset();
    chk("t6_bad_clear", bad_op, 8'h00);
    release_run();
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("t6_noissue_c%0d", c), issue, 8'h00);
      if (c == 2) begin
        chk("t6_bad_op",  bad_op,  8'h01);
        chk("t6_addr1",   pm_addr, 8'h01);
      end
    end
    for (int c = 4; c < 10; c++) begin
      step();
      chk($sformatf("t6_halted_c%0d", c), halted, 8'h01);
      chk($sformatf("t6_pm_rd_c%0d", c),  pm_rd,  8'h00);
      if (c == 6) run = 1'b0;
      if (c == 7) run = 1'b1;
    end
    chk("t6_bad_sticky", bad_op, 8'h01);
    reset = 1'b1;
    step();
    chk("t6_rst_halted", halted,  8'h00);
    chk("t6_rst_bad",    bad_op,  8'h00);
    chk("t6_rst_addr",   pm_addr, 8'h00);
    reset = 1'b0;
    step();
    chk("t6_pc0_rd",   pm_rd,   8'h01);
    chk("t6_pc0_addr", pm_addr, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
